// File: rtl/mmio_gpio_timer.sv
// mmio_gpio_timer
//   Memory-mapped GPIO + timer responder for the CPU data-memory bus.
//   A 32-byte register window at BASE_ADDR holds an LED register, a
//   synchronized switch input with sticky change flags, a free-running
//   32-bit timer with compare match, and a level interrupt.
//
//   Bus semantics: there is no handshake. A read returns the selected
//   register combinationally in the same cycle (no wait states, no side
//   effects). A write commits at the rising edge of i_clk whenever
//   i_mem_we=1 and the address lies in the window. o_hit tells the top
//   level to select this block's read data instead of the RAM's.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        asynchronous reset, active-low
//   i_mem_addr   byte address (bits [1:0] ignored, word accesses only)
//   i_mem_we     write strobe
//   i_mem_wdata  write data
//   o_mem_rdata  read data, zero when not hit or unmapped
//   o_hit        address lies inside the register window
//   i_sw         asynchronous switch inputs
//   o_led        LED register value
//   o_irq        level interrupt request
//
// Register map (byte offset)
//   0x00 LED RW | 0x04 SW RO | 0x08 SWCHG W1C | 0x0C TIMER RW
//   0x10 TCMP RW | 0x14 STATUS W1C (bit0 MATCH)
//   0x18 CTRL RW (bit0 TEN, bit1 TIE, bit2 SIE, bit3 ARL) | 0x1C unmapped
module mmio_gpio_timer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int                    LED_WIDTH  = 8,
  parameter int                    SW_WIDTH   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic                  i_mem_we,
  input  logic [DATA_WIDTH-1:0] i_mem_wdata,
  output logic [DATA_WIDTH-1:0] o_mem_rdata,
  output logic                  o_hit,
  input  logic [SW_WIDTH-1:0]   i_sw,
  output logic [LED_WIDTH-1:0]  o_led,
  output logic                  o_irq
);

  localparam logic [2:0] IDX_LED    = 3'd0;
  localparam logic [2:0] IDX_SW     = 3'd1;
  localparam logic [2:0] IDX_SWCHG  = 3'd2;
  localparam logic [2:0] IDX_TIMER  = 3'd3;
  localparam logic [2:0] IDX_TCMP   = 3'd4;
  localparam logic [2:0] IDX_STATUS = 3'd5;
  localparam logic [2:0] IDX_CTRL   = 3'd6;

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic       hit;
  logic [2:0] idx;
  logic       wr;

  assign hit = (i_mem_addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
  assign idx = i_mem_addr[4:2];
  assign wr  = i_mem_we & hit;

  // Byte-lane bits are deliberately ignored: only word accesses exist.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_mem_addr[1:0];

  logic wr_led, wr_swchg, wr_timer, wr_tcmp, wr_status, wr_ctrl;
  assign wr_led    = wr && (idx == IDX_LED);
  assign wr_swchg  = wr && (idx == IDX_SWCHG);
  assign wr_timer  = wr && (idx == IDX_TIMER);
  assign wr_tcmp   = wr && (idx == IDX_TCMP);
  assign wr_status = wr && (idx == IDX_STATUS);
  assign wr_ctrl   = wr && (idx == IDX_CTRL);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [LED_WIDTH-1:0] led_q,   led_d;
  logic [SW_WIDTH-1:0]  sync1_q, sync2_q, sync3_q;
  logic [SW_WIDTH-1:0]  swchg_q, swchg_d;
  logic [31:0]          timer_q, timer_d;
  logic [31:0]          tcmp_q,  tcmp_d;
  logic                 match_q, match_d;
  logic [3:0]           ctrl_q,  ctrl_d;

  logic ten, tie, sie, arl;
  assign ten = ctrl_q[0];
  assign tie = ctrl_q[1];
  assign sie = ctrl_q[2];
  assign arl = ctrl_q[3];

  // Compare uses the pre-update timer value, independent of a same-cycle
  // TIMER write.
  logic match_now;
  assign match_now = ten && (timer_q == tcmp_q);

  always_comb begin
    led_d   = led_q;
    tcmp_d  = tcmp_q;
    ctrl_d  = ctrl_q;
    timer_d = timer_q;

    if (wr_led)  led_d  = i_mem_wdata[LED_WIDTH-1:0];
    if (wr_tcmp) tcmp_d = i_mem_wdata[31:0];
    if (wr_ctrl) ctrl_d = i_mem_wdata[3:0];

    if (wr_timer)               timer_d = i_mem_wdata[31:0];
    else if (match_now && arl)  timer_d = '0;
    else if (ten)               timer_d = timer_q + 32'd1;

    // Sticky flags: a same-cycle set wins over a W1C clear.
    swchg_d = (swchg_q & ~(wr_swchg ? i_mem_wdata[SW_WIDTH-1:0] : '0))
            | (sync2_q ^ sync3_q);
    match_d = (match_q & ~(wr_status & i_mem_wdata[0])) | match_now;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      led_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      swchg_q <= '0;
      timer_q <= '0;
      tcmp_q  <= 32'hFFFF_FFFF;
      match_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      led_q   <= led_d;
      sync1_q <= i_sw;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      swchg_q <= swchg_d;
      timer_q <= timer_d;
      tcmp_q  <= tcmp_d;
      match_q <= match_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // ---------------------------------------------------------------------
  // Read path (combinational, zero-extended)
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rdata_c;

  always_comb begin
    rdata_c = '0;
    if (hit) begin
      case (idx)
        IDX_LED:    rdata_c[LED_WIDTH-1:0] = led_q;
        IDX_SW:     rdata_c[SW_WIDTH-1:0]  = sync2_q;
        IDX_SWCHG:  rdata_c[SW_WIDTH-1:0]  = swchg_q;
        IDX_TIMER:  rdata_c[31:0]          = timer_q;
        IDX_TCMP:   rdata_c[31:0]          = tcmp_q;
        IDX_STATUS: rdata_c[0]             = match_q;
        IDX_CTRL:   rdata_c[3:0]           = ctrl_q;
        default:    rdata_c                = '0;
      endcase
    end
  end

  assign o_mem_rdata = rdata_c;
  assign o_hit       = hit;
  assign o_led       = led_q;
  // Register-only interrupt: no combinational path from the bus.
  assign o_irq       = (match_q & tie) | ((|swchg_q) & sie);

endmodule

// File: tb/tb_mmio_gpio_timer.sv
`timescale 1ns/1ps
module tb_mmio_gpio_timer;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_mem_addr;
  logic        i_mem_we;
  logic [31:0] i_mem_wdata;
  logic [31:0] o_mem_rdata;
  logic        o_hit;
  logic [3:0]  i_sw;
  logic [7:0]  o_led;
  logic        o_irq;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  mmio_gpio_timer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(32'hFFFF_0000),
    .LED_WIDTH(8), .SW_WIDTH(4)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mem_addr(i_mem_addr),
    .i_mem_we(i_mem_we), .i_mem_wdata(i_mem_wdata),
    .o_mem_rdata(o_mem_rdata), .o_hit(o_hit), .i_sw(i_sw),
    .o_led(o_led), .o_irq(o_irq)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #50 i_clk = ~i_clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------
  // Behavioural model: register file as plain variables, switch path as
  // a short history of sampled inputs (index k = sampled k+1 edges ago).
  // -------------------------------------------------------------------
  logic [7:0]  m_led   = 8'h0;
  logic [3:0]  m_swchg = 4'h0;
  logic [31:0] m_timer = 32'h0;
  logic [31:0] m_tcmp  = 32'hFFFF_FFFF;
  logic        m_match = 1'b0;
  logic [3:0]  m_ctrl  = 4'h0;
  logic [3:0]  sw_hist [$] = '{4'h0, 4'h0, 4'h0};

  function automatic bit in_window(input logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (in_window(a)) begin
      case (a[4:2])
        3'd0: v = {24'h0, m_led};
        3'd1: v = {28'h0, sw_hist[1]};
        3'd2: v = {28'h0, m_swchg};
        3'd3: v = m_timer;
        3'd4: v = m_tcmp;
        3'd5: v = {31'h0, m_match};
        3'd6: v = {28'h0, m_ctrl};
        default: v = 32'h0;
      endcase
    end
    return v;
  endfunction

  function automatic logic m_irq();
    return (m_match & m_ctrl[1]) | ((|m_swchg) & m_ctrl[2]);
  endfunction

  task automatic model_step();
    bit          wr;
    logic [2:0]  ix;
    bit          ten;
    bit          cmp_hit;
    logic [3:0]  changed;
    logic [31:0] nt;
    wr      = i_mem_we && in_window(i_mem_addr);
    ix      = i_mem_addr[4:2];
    ten     = m_ctrl[0];
    cmp_hit = ten && (m_timer == m_tcmp);
    changed = sw_hist[1] ^ sw_hist[2];

    if (wr && ix == 3'd3)        nt = i_mem_wdata;
    else if (cmp_hit && m_ctrl[3]) nt = 32'h0;
    else if (ten)                nt = m_timer + 32'd1;
    else                         nt = m_timer;

    if (wr && ix == 3'd2) m_swchg = m_swchg & ~i_mem_wdata[3:0];
    m_swchg = m_swchg | changed;
    if (wr && ix == 3'd5 && i_mem_wdata[0]) m_match = 1'b0;
    if (cmp_hit) m_match = 1'b1;
    if (wr && ix == 3'd0) m_led  = i_mem_wdata[7:0];
    if (wr && ix == 3'd4) m_tcmp = i_mem_wdata;
    if (wr && ix == 3'd6) m_ctrl = i_mem_wdata[3:0];
    m_timer = nt;
    sw_hist = '{i_sw, sw_hist[0], sw_hist[1]};
  endtask

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      m_led = 8'h0; m_swchg = 4'h0; m_timer = 32'h0; m_tcmp = 32'hFFFF_FFFF;
      m_match = 1'b0; m_ctrl = 4'h0;
      sw_hist = '{4'h0, 4'h0, 4'h0};
    end else begin
      model_step();
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge i_clk) begin
    #1;
    if (chk_en) begin
      check("rdata", o_mem_rdata, m_read(i_mem_addr));
      check("hit",   {31'h0, o_hit}, {31'h0, in_window(i_mem_addr)});
      check("led",   {24'h0, o_led}, {24'h0, m_led});
      check("irq",   {31'h0, o_irq}, {31'h0, m_irq()});
    end
  end

  // -------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at a falling edge)
  // -------------------------------------------------------------------
  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    i_mem_addr  = BASE + off;
    i_mem_we    = 1'b1;
    i_mem_wdata = data;
    @(negedge i_clk);
    i_mem_we    = 1'b0;
  endtask

  task automatic idle(input int n);
    i_mem_we = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  // Literal read check; does not advance the clock.
  task automatic rd_expect(input string name, input logic [31:0] off, input logic [31:0] exp);
    #2;
    i_mem_we   = 1'b0;
    i_mem_addr = BASE + off;
    #1;
    check(name, o_mem_rdata, exp);
  endtask

  // -------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------
  initial begin
    i_rst = 1'b0; i_mem_addr = BASE; i_mem_we = 1'b0; i_mem_wdata = 32'h0; i_sw = 4'h0;
    repeat (3) @(negedge i_clk);
    i_rst  = 1'b1;
    chk_en = 1'b1;

    // reset values
    rd_expect("rst_led",    32'h00, 32'h0);
    rd_expect("rst_sw",     32'h04, 32'h0);
    rd_expect("rst_swchg",  32'h08, 32'h0);
    rd_expect("rst_timer",  32'h0C, 32'h0);
    rd_expect("rst_tcmp",   32'h10, 32'hFFFF_FFFF);
    rd_expect("rst_status", 32'h14, 32'h0);
    rd_expect("rst_ctrl",   32'h18, 32'h0);
    rd_expect("rst_unmap",  32'h1C, 32'h0);
    check("rst_irq", {31'h0, o_irq}, 32'h0);
    check("rst_oled", {24'h0, o_led}, 32'h0);
    rd_expect("oow_rdata", 32'h20, 32'h0);
    check("oow_hit", {31'h0, o_hit}, 32'h0);
    @(negedge i_clk);

    // LED
    wr(32'h00, 32'h1A5);
    check("led_out", {24'h0, o_led}, 32'hA5);
    rd_expect("led_rd", 32'h00, 32'hA5);
    i_mem_addr = BASE; i_mem_we = 1'b0; i_mem_wdata = 32'h3C;
    @(negedge i_clk);
    rd_expect("led_nowe", 32'h00, 32'hA5);

    // timer compare with auto-reload
    wr(32'h10, 32'd5);
    wr(32'h18, 32'hB);
    rd_expect("tmr_start", 32'h0C, 32'd0);
    idle(5);
    rd_expect("tmr_at5", 32'h0C, 32'd5);
    rd_expect("tmr_nomatch_yet", 32'h14, 32'd0);
    idle(1);
    rd_expect("tmr_reload", 32'h0C, 32'd0);
    rd_expect("match_set", 32'h14, 32'd1);
    check("match_irq", {31'h0, o_irq}, 32'h1);
    idle(5);
    wr(32'h14, 32'h1);                 // clear in a match cycle: set wins
    rd_expect("match_setwins", 32'h14, 32'd1);
    wr(32'h14, 32'h1);                 // clear in a non-match cycle
    rd_expect("match_clr", 32'h14, 32'd0);
    check("match_clr_irq", {31'h0, o_irq}, 32'h0);

    // wrap without flag
    wr(32'h18, 32'h1);
    wr(32'h10, 32'h10);
    wr(32'h0C, 32'hFFFF_FFFE);
    rd_expect("wrap0", 32'h0C, 32'hFFFF_FFFE);
    idle(1);
    rd_expect("wrap1", 32'h0C, 32'hFFFF_FFFF);
    idle(1);
    rd_expect("wrap2", 32'h0C, 32'h0);
    idle(1);
    rd_expect("wrap3", 32'h0C, 32'h1);
    rd_expect("wrap_nomatch", 32'h14, 32'h0);
    wr(32'h0C, 32'h100);
    rd_expect("tmr_load_wins", 32'h0C, 32'h100);

    // switches
    wr(32'h18, 32'h4);
    i_sw = 4'h5;
    idle(1);
    rd_expect("sw_lat1", 32'h04, 32'h0);
    idle(1);
    rd_expect("sw_lat2", 32'h04, 32'h5);
    rd_expect("swchg_lat2", 32'h08, 32'h0);
    idle(1);
    rd_expect("swchg_lat3", 32'h08, 32'h5);
    check("sw_irq", {31'h0, o_irq}, 32'h1);
    wr(32'h08, 32'h1);
    rd_expect("swchg_w1c", 32'h08, 32'h4);
    check("sw_irq_hold", {31'h0, o_irq}, 32'h1);
    wr(32'h08, 32'h4);
    rd_expect("swchg_clr", 32'h08, 32'h0);
    check("sw_irq_clr", {31'h0, o_irq}, 32'h0);

    // asynchronous reset mid-operation
    wr(32'h10, 32'd3);
    wr(32'h18, 32'hF);
    wr(32'h0C, 32'd0);
    i_sw = 4'hA;
    idle(5);
    i_mem_addr = BASE + 32'h0C;
    #3;
    check("pre_rst_irq", {31'h0, o_irq}, 32'h1);
    i_rst = 1'b0;
    #1;
    check("arst_irq", {31'h0, o_irq}, 32'h0);
    check("arst_led", {24'h0, o_led}, 32'h0);
    check("arst_timer", o_mem_rdata, 32'h0);
    i_mem_addr = BASE + 32'h10;
    #1;
    check("arst_tcmp", o_mem_rdata, 32'hFFFF_FFFF);
    i_mem_addr = BASE + 32'h14;
    #1;
    check("arst_status", o_mem_rdata, 32'h0);
    @(negedge i_clk);
    i_rst = 1'b1;

    // randomized phase
    for (int c = 0; c < 2000; c++) begin
      int r;
      logic [31:0] ix;
      r  = $urandom_range(0, 9);
      ix = 32'($urandom_range(0, 7));
      if (r < 8)       i_mem_addr = BASE + (ix << 2) + 32'($urandom_range(0, 3));
      else if (r == 8) i_mem_addr = BASE + 32'h20 + 32'($urandom_range(0, 31));
      else             i_mem_addr = $urandom;
      i_mem_we    = ($urandom_range(0, 9) < 4);
      i_mem_wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) i_sw = 4'($urandom_range(0, 15));
      @(negedge i_clk);
    end
    i_mem_we = 1'b0;
    @(negedge i_clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
